// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C master
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP, DONE
    } state_e;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: divides clk into SCL quarter-phases while a transaction runs
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       tick,
    output logic [1:0] q,
    output logic       last_bit_cycle
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       q_q, q_d;

    assign tick           = run && cnt_q == CNT_W'(CLK_DIV - 1);
    assign q              = q_q;
    assign last_bit_cycle = tick && q_q == Q3;

    // Held at zero outside a transaction so every START begins on a fresh q0.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        q_d   = tick ? q_q + 2'd1 : q_q;
        if (!run) begin
            cnt_d = '0;
            q_d   = Q0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= Q0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end
endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-transaction I2C master (START, address, one data byte, STOP)
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic [7:0]        rdata,
    output logic              scl,
    output logic              sda_oe,
    input  logic              sda_in
);
    localparam int TX_W = (ADDR_W + 1 > BITS_PER_BYTE) ? ADDR_W + 1 : BITS_PER_BYTE;
    localparam int CW   = $clog2(TX_W);

    state_e          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TX_W-1:0] tx_q, tx_d;
    logic [7:0]      rx_q, rx_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic            rw_q, rw_d, ack_err_q, ack_err_d;
    logic            tick, last, sample, in_bit;
    logic [1:0]      q;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk            (clk),
        .rst            (rst),
        .run            (busy),
        .tick           (tick),
        .q              (q),
        .last_bit_cycle (last)
    );

    assign sample  = tick && q == Q2;
    assign in_bit  = state_q inside {ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK};
    assign busy    = state_q != IDLE && state_q != DONE;
    assign done    = state_q == DONE;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign scl     = in_bit ? q > Q1 : (state_q == STOP) ? q != Q0 : 1'b1;
    // START/STOP move SDA mid-bit with SCL high; data bits only move it on entry to q0.
    assign sda_oe  = (state_q == START) ? q > Q1 :
                     (state_q == STOP) ? q <= Q1 :
                     (state_q == ADDR || state_q == WDATA) ? ~tx_q[TX_W-1] : 1'b0;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = START;
                rw_d      = rw;
                wdata_d   = wdata;
                tx_d      = TX_W'({dev_addr, rw}) << (TX_W - ADDR_W - 1);
                ack_err_d = 1'b0;
                bit_cnt_d = '0;
            end
            START: if (last) state_d = ADDR;
            ADDR: if (last) begin
                tx_d      = tx_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(ADDR_W)) begin
                    state_d   = ADDR_ACK;
                    bit_cnt_d = '0;
                end
            end
            ADDR_ACK: begin
                if (sample && sda_in != I2C_ACK) ack_err_d = 1'b1;
                if (last) begin
                    state_d = ack_err_q ? STOP : rw_q ? RDATA : WDATA;
                    tx_d    = TX_W'(wdata_q) << (TX_W - BITS_PER_BYTE);
                end
            end
            WDATA: if (last) begin
                tx_d      = tx_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(BITS_PER_BYTE - 1)) begin
                    state_d   = WACK;
                    bit_cnt_d = '0;
                end
            end
            WACK: begin
                if (sample && sda_in == I2C_NACK) ack_err_d = 1'b1;
                if (last) state_d = STOP;
            end
            RDATA: begin
                if (sample) rx_d = {rx_q[6:0], sda_in};
                if (last) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(BITS_PER_BYTE - 1)) begin
                        state_d   = RACK;
                        bit_cnt_d = '0;
                    end
                end
            end
            RACK: if (last) state_d = STOP;
            // rdata is loaded on the way into DONE so it is valid alongside the done pulse.
            STOP: if (last) begin
                state_d = DONE;
                if (rw_q && !ack_err_q) rdata_d = rx_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed transactions against a simple I2C responder and bus monitor
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0, sda_in;
    logic [6:0] dev_addr = '0;
    logic [7:0] wdata = '0, rdata;
    logic       busy, done, ack_err, scl, sda_oe;

    int checks = 0, errors = 0;

    logic        resp_low = 1'b0, ack_addr = 1'b1, ack_data = 1'b1, rd_mode = 1'b0;
    logic [7:0]  rd_byte = '0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    int          fall_cnt = 0, n_start = 0, n_stop = 0, n_done = 0, nbits = 0, cyc = 0;
    logic [31:0] bits = '0;

    assign sda_in = ~(sda_oe | resp_low);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .rdata    (rdata),
        .scl      (scl),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Responder drives after SCL falls; monitor logs SDA at each SCL rise and START/STOP edges.
    always @(negedge clk) begin : mon
        logic line;
        int   k;
        line = ~(sda_oe | resp_low);
        if (prev_scl && scl && prev_sda && !line) begin
            n_start++;
            fall_cnt = 0;
            nbits    = 0;
            bits     = '0;
            n_stop   = 0;
        end
        if (prev_scl && scl && !prev_sda && line) n_stop++;
        if (!prev_scl && scl) begin
            bits = {bits[30:0], line};
            nbits++;
        end
        if (prev_scl && !scl) begin
            fall_cnt++;
            k = fall_cnt - 1;
            resp_low = (k == 8) ? ack_addr :
                       (ack_addr && rd_mode && k >= 9 && k <= 16) ? ~rd_byte[16-k] :
                       (ack_addr && !rd_mode && k == 17) ? ack_data : 1'b0;
        end
        if (done) n_done++;
        prev_scl = scl;
        prev_sda = ~(sda_oe | resp_low);
    end

    task automatic run_txn(input string tag, input logic r, input logic [6:0] a, input logic [7:0] d,
                           input logic ack_a, input logic ack_d, input logic [7:0] rb, input bit mid,
                           input int exp_lat, input logic exp_err, input logic [7:0] exp_rd,
                           input logic [31:0] exp_bits, input int exp_nbits);
        int s0, d0, c0;
        bit got;
        ack_addr = ack_a;
        ack_data = ack_d;
        rd_mode  = r;
        rd_byte  = rb;
        s0 = n_start;
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; rw = r; dev_addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        check({tag, "_busy"}, busy, 1);
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (mid) begin
                start = (i == 40);
                rw = ~r; dev_addr = 7'h12; wdata = 8'h00;
            end
            if (done) begin
                got = 1;
                check({tag, "_lat"}, cyc - c0, exp_lat);
                check({tag, "_ack_err"}, ack_err, exp_err);
                check({tag, "_rdata"}, rdata, exp_rd);
                check({tag, "_busy_at_done"}, busy, 0);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        repeat (3) @(negedge clk);
        check({tag, "_bits"}, bits, exp_bits);
        check({tag, "_nbits"}, nbits, exp_nbits);
        check({tag, "_starts"}, n_start - s0, 1);
        check({tag, "_stops"}, n_stop, 1);
        check({tag, "_dones"}, n_done - d0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn("wr", 1'b0, 7'h50, 8'hAB, 1'b1, 1'b1, 8'h00, 0, 80*CLK_DIV, 1'b0, 8'h00,
                {8'hA0, 1'b0, 8'hAB, 1'b0, 1'b0}, 19);
        run_txn("addr_nack", 1'b0, 7'h50, 8'hAB, 1'b0, 1'b1, 8'h00, 0, 44*CLK_DIV, 1'b1, 8'h00,
                {8'hA0, 1'b1, 1'b0}, 10);
        run_txn("data_nack", 1'b0, 7'h50, 8'hFF, 1'b1, 1'b0, 8'h00, 0, 80*CLK_DIV, 1'b1, 8'h00,
                {8'hA0, 1'b0, 8'hFF, 1'b1, 1'b0}, 19);
        run_txn("mid_start", 1'b0, 7'h50, 8'hAB, 1'b1, 1'b1, 8'h00, 1, 80*CLK_DIV, 1'b0, 8'h00,
                {8'hA0, 1'b0, 8'hAB, 1'b0, 1'b0}, 19);

        ack_addr = 1'b1; rd_mode = 1'b0;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; dev_addr = 7'h50; wdata = 8'hAB;
        @(negedge clk);
        start = 1'b0;
        repeat (16 + 4*16 + 6) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_scl", scl, 1);
        check("rst_mid_sda_oe", sda_oe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn("wr_after_rst", 1'b0, 7'h50, 8'hAB, 1'b1, 1'b1, 8'h00, 0, 80*CLK_DIV, 1'b0, 8'h00,
                {8'hA0, 1'b0, 8'hAB, 1'b0, 1'b0}, 19);
        run_txn("rd", 1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, 0, 80*CLK_DIV, 1'b0, 8'h3C,
                {8'hA1, 1'b0, 8'h3C, 1'b1, 1'b0}, 19);
        run_txn("rd_addr_nack", 1'b1, 7'h50, 8'h00, 1'b0, 1'b1, 8'h5A, 0, 44*CLK_DIV, 1'b1, 8'h3C,
                {8'hA1, 1'b1, 1'b0}, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-transaction I2C master.
- Generates START, one 7-bit address plus R/W byte, one data byte (write or read), ACK/NACK handling and STOP.
- Acts as the initiating end for the memory controller's I2C slave port on the memory subsystem bus.
- Used as the driver-side RTL for system-level memory write/read tests and by any on-chip agent that needs memory-controller access.

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-phase (>=1). One SCL bit period = 4*CLK_DIV clocks.
- ADDR_W, 7: device address width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- rw  in  1  0=write, 1=read; captured with start
- dev_addr  in  ADDR_W  target address; captured with start
- wdata  in  8  write byte; captured with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  valid with done: 1 if address or write-data byte was NACKed
- rdata  out  8  read byte; updated only at done of a successful read
- scl  out  1  SCL level (1 = released/high)
- sda_oe  out  1  1 = pull SDA low; 0 = release
- sda_in  in  1  sampled SDA line level

Behaviour:
- Reset values: scl=1, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, state=IDLE, divider=0. Synchronous reset mid-transaction returns to IDLE on the next edge and releases the bus immediately; no STOP is generated.
- Phase generator: a counter 0..CLK_DIV-1 produces a tick. The phase index q cycles 0..3, advancing on each tick.
- Bit phases:
  - q0, q1: scl=0.
  - q2, q3: scl=1.
  - sda_oe changes only on entry to q0.
  - sda_in is sampled on the last clock of q2.
- States:
  - IDLE: scl=1, sda_oe=0. On start=1, latch rw, dev_addr, wdata, clear ack_err, set busy, go to START.
  - START (1 bit period): q0/q1 SDA released and scl=1; q2/q3 sda_oe=1 and scl=1 (falling SDA while SCL high). Then go to ADDR.
  - ADDR (8 bits): shift out {dev_addr, rw} MSB first; sda_oe = ~bit.
  - ADDR_ACK: release SDA and sample. If 0 (ACK), go to WDATA when rw=0, or RDATA when rw=1. If 1 (NACK), set ack_err=1 and go to STOP.
  - WDATA (8 bits): wdata MSB first. Then WACK.
  - WACK: sample; on 1 set ack_err=1. Go to STOP either way.
  - RDATA (8 bits): SDA released; shift sda_in into a shift register MSB first.
  - RACK: master drives NACK (SDA released, bit=1) to end the read. Then STOP.
  - STOP (1 bit period): q0/q1 sda_oe=1 with scl=0 then scl=1; q2/q3 sda_oe=0 with scl=1 (rising SDA while SCL high). Then DONE.
  - DONE (1 clock): done=1, busy=0. Load rdata from the shift register if rw=1 and ack_err=0. Go to IDLE.
- Latency for a full transaction: 20 bit periods = 80*CLK_DIV clocks from the start-accept edge to the DONE cycle. An address NACK shortens this to 11 bit periods.
- start while busy is ignored, with no queueing. start in the same cycle as rst: rst wins.
- SDA never changes while scl=1, except the START and STOP edges.
- sda_in is not internally synchronized; the external line must be synchronous to clk.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum (IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP, DONE)
  - phase constants Q0..Q3
  - I2C_ACK=1'b0, I2C_NACK=1'b1
  - BITS_PER_BYTE=8
- One sub-module, i2c_phase_gen: CLK_DIV divider, outputs tick, q[1:0] and last_bit_cycle. The FSM, shift registers and bit counter stay in i2c_master_ctrl.

Test Plan:
- Write: dev_addr=7'h50, rw=0, wdata=8'hAB, responder ACKs both bytes. SDA bits seen on SCL rises are 1010000,0 then 10101011. done arrives at 80*CLK_DIV clocks, with ack_err=0 and rdata unchanged (8'h00).
- Read: dev_addr=7'h50, rw=1, responder ACKs the address and drives 8'h3C. Master releases SDA on the 9th data-phase bit (NACK). done with rdata=8'h3C and ack_err=0.
- Address NACK: responder leaves SDA high in ADDR_ACK. No data byte is clocked; STOP follows immediately. done at 44*CLK_DIV clocks with ack_err=1; rdata stays 8'h00.
- Write-data NACK: address ACKed, data 8'hFF NACKed. ack_err=1, STOP generated, done at 80*CLK_DIV clocks.
- start pulsed again mid-transaction with different dev_addr/wdata. The bus sequence is unchanged, and exactly one done is produced.
- rst asserted during bit 4 of ADDR. Next cycle: scl=1, sda_oe=0, busy=0, done=0. A new start afterwards completes normally.
